serpent_req_arbiter: RTL and testbench

SERPENT_REQ_ARBITER -- requirements
Module: serpent_req_arbiter

---
 rtl/serpent_req_arbiter_if.sv | 39 +++
 rtl/serpent_req_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_serpent_req_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serpent_req_arbiter_if.sv
// Request/response/core bundle for serpent_req_arbiter.
// slave: arbiter side; master: requesters plus encrypt core.
interface serpent_req_arbiter_if;
    localparam int unsigned N_REQ  = 2;
    localparam int unsigned KEY_W  = 256;
    localparam int unsigned DATA_W = 128;

    logic [N_REQ-1:0]  i_req_valid;
    logic [N_REQ-1:0]  o_req_ready;
    logic [KEY_W-1:0]  i_key0;
    logic [KEY_W-1:0]  i_key1;
    logic [DATA_W-1:0] i_data0;
    logic [DATA_W-1:0] i_data1;
    logic [N_REQ-1:0]  o_rsp_valid;
    logic [N_REQ-1:0]  i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_data;
    logic              o_rsp_err;
    logic              o_core_start;
    logic [KEY_W-1:0]  o_core_key;
    logic [DATA_W-1:0] o_core_data;
    logic [DATA_W-1:0] i_core_data;
    logic              i_core_done;
    logic              o_busy;
    logic              o_grant;

    modport slave (
        input  i_req_valid, i_key0, i_key1, i_data0, i_data1,
        input  i_rsp_ready, i_core_data, i_core_done,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
        output o_core_start, o_core_key, o_core_data, o_busy, o_grant
    );

    modport master (
        output i_req_valid, i_key0, i_key1, i_data0, i_data1,
        output i_rsp_ready, i_core_data, i_core_done,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
        input  o_core_start, o_core_key, o_core_data, o_busy, o_grant
    );
endinterface

// File: rtl/serpent_req_arbiter.sv
// Two-requester round-robin front end for a single Serpent encrypt core.
// Optional abort of hung jobs: define SERPENT_ARB_TIMEOUT_EN (limit = TIMEOUT RUN cycles).
module serpent_req_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    serpent_req_arbiter_if.slave  bus
);
    localparam int unsigned N_REQ  = 2;
    localparam int unsigned KEY_W  = 256;
    localparam int unsigned DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [N_REQ-1:0]  req_ready_q,  req_ready_nxt;
    logic [N_REQ-1:0]  rsp_valid_q,  rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_data_q,   rsp_data_nxt;
    logic              rsp_err_q,    rsp_err_nxt;
    logic              core_start_q, core_start_nxt;
    logic [KEY_W-1:0]  core_key_q,   core_key_nxt;
    logic [DATA_W-1:0] core_data_q,  core_data_nxt;
    logic              busy_q,       busy_nxt;
    logic              grant_q,      grant_nxt;
    logic              prio_q,       prio_nxt;

    logic any_req_c;
    logic win_c;
    logic rsp_accept_c;
    logic timeout_c;

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("serpent_req_arbiter: TIMEOUT must be nonzero");
    end

    assign any_req_c    = |bus.i_req_valid;
    assign rsp_accept_c = bus.i_rsp_ready[grant_q];

    // Round-robin pick: a lone requester wins, a tie goes to prio_q
    always_comb begin
        win_c = 1'b0;
        case (bus.i_req_valid)
            2'b10:   win_c = 1'b1;
            2'b11:   win_c = prio_q;
            default: win_c = 1'b0;
        endcase
    end

`ifdef SERPENT_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] run_cnt_q;

    // Counts cycles spent in RUN; cleared whenever the FSM is elsewhere
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            run_cnt_q <= '0;
        end else if (state != ST_RUN) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_q + CNT_W'(1);
        end
    end

    assign timeout_c = (state == ST_RUN) && (run_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req_c) state_nxt = ST_RUN;
            ST_RUN:  if (bus.i_core_done || timeout_c) state_nxt = ST_RESP;
            ST_RESP: if (rsp_accept_c) state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless a transition updates it
    always_comb begin
        req_ready_nxt  = '0;
        rsp_valid_nxt  = rsp_valid_q;
        rsp_data_nxt   = rsp_data_q;
        rsp_err_nxt    = rsp_err_q;
        core_start_nxt = core_start_q;
        core_key_nxt   = core_key_q;
        core_data_nxt  = core_data_q;
        busy_nxt       = (state_nxt != ST_IDLE);
        grant_nxt      = grant_q;
        prio_nxt       = prio_q;
        case (state)
            ST_IDLE: begin
                if (any_req_c) begin
                    req_ready_nxt[win_c] = 1'b1;
                    grant_nxt            = win_c;
                    prio_nxt             = ~win_c;
                    core_key_nxt         = win_c ? bus.i_key1  : bus.i_key0;
                    core_data_nxt        = win_c ? bus.i_data1 : bus.i_data0;
                    core_start_nxt       = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.i_core_done) begin
                    core_start_nxt         = 1'b0;
                    rsp_data_nxt           = bus.i_core_data;
                    rsp_err_nxt            = 1'b0;
                    rsp_valid_nxt          = '0;
                    rsp_valid_nxt[grant_q] = 1'b1;
                end else if (timeout_c) begin
                    core_start_nxt         = 1'b0;
                    rsp_data_nxt           = '0;
                    rsp_err_nxt            = 1'b1;
                    rsp_valid_nxt          = '0;
                    rsp_valid_nxt[grant_q] = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_accept_c) begin
                    rsp_valid_nxt = '0;
                    rsp_err_nxt   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output and job registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            core_start_q <= 1'b0;
            core_key_q   <= '0;
            core_data_q  <= '0;
            busy_q       <= 1'b0;
            grant_q      <= 1'b0;
            prio_q       <= 1'b0;
        end else begin
            req_ready_q  <= req_ready_nxt;
            rsp_valid_q  <= rsp_valid_nxt;
            rsp_data_q   <= rsp_data_nxt;
            rsp_err_q    <= rsp_err_nxt;
            core_start_q <= core_start_nxt;
            core_key_q   <= core_key_nxt;
            core_data_q  <= core_data_nxt;
            busy_q       <= busy_nxt;
            grant_q      <= grant_nxt;
            prio_q       <= prio_nxt;
        end
    end

    assign bus.o_req_ready  = req_ready_q;
    assign bus.o_rsp_valid  = rsp_valid_q;
    assign bus.o_rsp_data   = rsp_data_q;
    assign bus.o_rsp_err    = rsp_err_q;
    assign bus.o_core_start = core_start_q;
    assign bus.o_core_key   = core_key_q;
    assign bus.o_core_data  = core_data_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_grant      = grant_q;
endmodule

// File: tb/tb_serpent_req_arbiter.sv
// Randomized scoreboard bench for serpent_req_arbiter with a behavioural core model.
module tb_serpent_req_arbiter;
    localparam int unsigned TIMEOUT_CYC = 16;

    typedef struct packed {
        logic [255:0] key;
        logic [127:0] data;
        logic [7:0]   gap;
        logic         hang;
    } job_t;

    typedef struct packed {
        logic [127:0] data;
        logic         err;
    } rsp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    job_t job_q [2][$];
    rsp_t exp_q [2][$];

    int checks = 0;
    int errors = 0;

    logic [1:0]   rsp_rdy;
    logic         core_done;
    logic [127:0] core_dout;
    bit           rsp_force_en  = 1'b0;
    logic [1:0]   rsp_force_val = 2'b00;
    bit           core_hang     = 1'b0;
    int           spur_cnt      = 0;

    serpent_req_arbiter_if bus ();

    serpent_req_arbiter #(.TIMEOUT(TIMEOUT_CYC)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    function automatic logic [127:0] ref_cipher(input logic [255:0] k, input logic [127:0] d);
        return d ^ k[127:0] ^ {k[191:128], k[255:192]} ^ 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requesters: each owns its valid/key/data and holds valid until it sees ready
    for (genvar g = 0; g < 2; g++) begin : g_req
        logic         v;
        logic         act;
        logic [255:0] k;
        logic [127:0] d;
        initial begin
            job_t j;
            rsp_t r;
            bit   got;
            v = 1'b0; act = 1'b0; k = '0; d = '0;
            forever begin
                @(posedge clk); #1;
                if (job_q[g].size() != 0) begin
                    act = 1'b1;
                    j = job_q[g].pop_front();
                    repeat (int'(j.gap)) begin @(posedge clk); #1; end
                    k = j.key; d = j.data; v = 1'b1;
                    r.err  = j.hang;
                    r.data = j.hang ? 128'h0 : ref_cipher(j.key, j.data);
                    exp_q[g].push_back(r);
                    got = 1'b0;
                    for (int c = 0; c < 3000 && !got; c++) begin
                        @(negedge clk);
                        if (rstn && bus.o_req_ready[g]) got = 1'b1;
                    end
                    check_eq($sformatf("req%0d_accepted_in_time", g), 256'(got), 256'(1));
                    @(posedge clk); #1;
                    v = 1'b0; act = 1'b0;
                end
            end
        end
    end

    assign bus.i_req_valid = {g_req[1].v, g_req[0].v};
    assign bus.i_key0      = g_req[0].k;
    assign bus.i_key1      = g_req[1].k;
    assign bus.i_data0     = g_req[0].d;
    assign bus.i_data1     = g_req[1].d;
    assign bus.i_rsp_ready = rsp_rdy;
    assign bus.i_core_done = core_done;
    assign bus.i_core_data = core_dout;

    // Response-ready driver: random per bit (owner or not) unless forced
    initial begin
        rsp_rdy = 2'b00;
        forever begin
            @(posedge clk); #1;
            rsp_rdy = rsp_force_en ? rsp_force_val : 2'($urandom);
        end
    end

    // Encrypt core model: random latency from start, optional hang, spurious pulses on request
    initial begin
        bit           active = 1'b0;
        bit           given  = 1'b0;
        int           lat    = 0;
        int           spur_seen = 0;
        logic         st;
        logic [255:0] ck, ck0;
        logic [127:0] cd, cd0;
        core_done = 1'b0; core_dout = '0; ck0 = '0; cd0 = '0;
        forever begin
            @(negedge clk);
            st = bus.o_core_start; ck = bus.o_core_key; cd = bus.o_core_data;
            @(posedge clk); #1;
            core_done = 1'b0;
            if (!rstn) begin
                active = 1'b0; given = 1'b0;
            end else if (st && !active) begin
                active = 1'b1; given = 1'b0; lat = $urandom_range(1, 6);
                ck0 = ck; cd0 = cd;
            end else if (st && active) begin
                check_eq("core_key_stable", ck, ck0);
                check_eq("core_data_stable", 256'(cd), 256'(cd0));
                if (lat > 0) lat--;
                if (lat == 0 && !given && !core_hang) begin
                    core_done = 1'b1; core_dout = ref_cipher(ck0, cd0); given = 1'b1;
                end
            end else if (!st) begin
                if (active && !core_hang) check_eq("core_start_held_until_done", 256'(given), 256'(1));
                active = 1'b0;
            end
            if (spur_seen != spur_cnt) begin
                spur_seen = spur_cnt;
                core_done = 1'b1;
                core_dout = rand256()[127:0];
            end
        end
    end

    // Monitor: arbitration model on grants, scoreboard pop on response handshakes
    initial begin
        bit           rr_model = 1'b0;
        bit           owner    = 1'b0;
        bit           exp_w;
        logic [1:0]   prev_v   = 2'b00;
        bit           pv_valid = 1'b0;
        bit           paccept  = 1'b0;
        logic [127:0] pdata    = '0;
        rsp_t         e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                rr_model = 1'b0; prev_v = 2'b00; pv_valid = 1'b0; paccept = 1'b0;
                continue;
            end
            if (bus.o_req_ready != 2'b00) begin
                exp_w = (prev_v == 2'b11) ? rr_model : prev_v[1];
                check_eq("req_ready_winner", 256'(bus.o_req_ready), 256'(exp_w ? 2'b10 : 2'b01));
                rr_model = ~exp_w;
                owner    = exp_w;
            end
            if (bus.o_rsp_valid != 2'b00) begin
                check_eq("rsp_valid_owner", 256'(bus.o_rsp_valid), 256'(owner ? 2'b10 : 2'b01));
                check_eq("grant_owner", 256'(bus.o_grant), 256'(owner));
                if (pv_valid && !paccept) check_eq("rsp_data_stable", 256'(bus.o_rsp_data), 256'(pdata));
                for (int n = 0; n < 2; n++) begin
                    if (bus.o_rsp_valid[n] && bus.i_rsp_ready[n]) begin
                        check_eq($sformatf("rsp%0d_was_expected", n), 256'(exp_q[n].size() != 0), 256'(1));
                        if (exp_q[n].size() != 0) begin
                            e = exp_q[n].pop_front();
                            check_eq($sformatf("rsp%0d_data", n), 256'(bus.o_rsp_data), 256'(e.data));
                            check_eq($sformatf("rsp%0d_err", n), 256'(bus.o_rsp_err), 256'(e.err));
                        end
                    end
                end
            end
            pv_valid = |bus.o_rsp_valid;
            paccept  = |(bus.o_rsp_valid & bus.i_rsp_ready);
            pdata    = bus.o_rsp_data;
            prev_v   = bus.i_req_valid;
        end
    end

    task automatic push_job(input int n, input logic [255:0] k, input logic [127:0] d,
                            input int gap, input bit hang);
        job_t j;
        j.key = k; j.data = d; j.gap = 8'(gap); j.hang = hang;
        job_q[n].push_back(j);
    endtask

    task automatic drain(input string tag, input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            done = (job_q[0].size() == 0) && (job_q[1].size() == 0) &&
                   (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
                   !g_req[0].act && !g_req[1].act && !bus.o_busy;
        end
        check_eq({tag, "_drained"}, 256'(done), 256'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_ready"},  256'(bus.o_req_ready),  256'(0));
        check_eq({tag, "_rsp_valid"},  256'(bus.o_rsp_valid),  256'(0));
        check_eq({tag, "_rsp_err"},    256'(bus.o_rsp_err),    256'(0));
        check_eq({tag, "_core_start"}, 256'(bus.o_core_start), 256'(0));
        check_eq({tag, "_busy"},       256'(bus.o_busy),       256'(0));
        check_eq({tag, "_grant"},      256'(bus.o_grant),      256'(0));
        check_eq({tag, "_rsp_data"},   256'(bus.o_rsp_data),   256'(0));
        check_eq({tag, "_core_key"},   bus.o_core_key,         256'(0));
        check_eq({tag, "_core_data"},  256'(bus.o_core_data),  256'(0));
    endtask

    task automatic wait_rsp(input string tag, input logic [1:0] mask, input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            seen = (bus.o_rsp_valid & mask) != 2'b00;
        end
        check_eq({tag, "_rsp_seen"}, 256'(seen), 256'(1));
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        logic [127:0] held;
        int           n_start;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rstn = 1'b1;

        // Simultaneous requests from reset, twice: 0,1 then 0,1
        @(negedge clk);
        push_job(0, rand256(), rand256()[127:0], 0, 1'b0);
        push_job(1, rand256(), rand256()[127:0], 0, 1'b0);
        drain("both_a", 500);
        push_job(0, rand256(), rand256()[127:0], 0, 1'b0);
        push_job(1, rand256(), rand256()[127:0], 0, 1'b0);
        drain("both_b", 500);

        // Requester 0 alone, all-zero key and plaintext
        push_job(0, 256'(0), 128'(0), 0, 1'b0);
        drain("zero_job", 300);

        // Response held off: valid/data stable, no new grant, core idle
        rsp_force_en = 1'b1; rsp_force_val = 2'b00;
        push_job(0, rand256(), rand256()[127:0], 0, 1'b0);
        wait_rsp("holdoff", 2'b01, 300);
        held = bus.o_rsp_data;
        push_job(1, rand256(), rand256()[127:0], 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("holdoff_rsp_valid",  256'(bus.o_rsp_valid),  256'(2'b01));
            check_eq("holdoff_rsp_data",   256'(bus.o_rsp_data),   256'(held));
            check_eq("holdoff_no_grant",   256'(bus.o_req_ready),  256'(0));
            check_eq("holdoff_core_start", 256'(bus.o_core_start), 256'(0));
        end
        rsp_force_val = 2'b01;
        @(negedge clk);
        rsp_force_en = 1'b0;
        drain("holdoff", 500);

        // Spurious core done in IDLE
        @(negedge clk);
        spur_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("spur_idle_busy",      256'(bus.o_busy),      256'(0));
            check_eq("spur_idle_rsp_valid", 256'(bus.o_rsp_valid), 256'(0));
        end

        // Spurious core done in GAP
        rsp_force_en = 1'b1; rsp_force_val = 2'b11;
        push_job(1, rand256(), rand256()[127:0], 0, 1'b0);
        wait_rsp("spur_gap", 2'b10, 300);
        spur_cnt++;
        @(negedge clk);
        check_eq("gap_rsp_valid", 256'(bus.o_rsp_valid),  256'(0));
        check_eq("gap_core_start", 256'(bus.o_core_start), 256'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("after_gap_busy",      256'(bus.o_busy),      256'(0));
            check_eq("after_gap_rsp_valid", 256'(bus.o_rsp_valid), 256'(0));
        end
        rsp_force_en = 1'b0;
        drain("spur_gap", 100);

`ifdef SERPENT_ARB_TIMEOUT_EN
        // Hung core: abort after TIMEOUT RUN cycles with err and zero data
        core_hang = 1'b1;
        rsp_force_en = 1'b1; rsp_force_val = 2'b00;
        push_job(1, rand256(), rand256()[127:0], 0, 1'b1);
        n_start = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.o_rsp_valid != 2'b00) break;
            if (bus.o_core_start) n_start++;
        end
        check_eq("timeout_run_cycles", 256'(n_start), 256'(TIMEOUT_CYC));
        check_eq("timeout_rsp_valid", 256'(bus.o_rsp_valid),  256'(2'b10));
        check_eq("timeout_rsp_err",   256'(bus.o_rsp_err),    256'(1));
        check_eq("timeout_rsp_data",  256'(bus.o_rsp_data),   256'(0));
        check_eq("timeout_core_off",  256'(bus.o_core_start), 256'(0));
        repeat (2) @(negedge clk);
        core_hang = 1'b0;
        rsp_force_val = 2'b10;
        @(negedge clk);
        rsp_force_en = 1'b0;
        drain("timeout", 300);
        rsp_force_en = 1'b1; rsp_force_val = 2'b00;
        push_job(1, rand256(), rand256()[127:0], 0, 1'b0);
        wait_rsp("after_timeout", 2'b10, 300);
        check_eq("after_timeout_err", 256'(bus.o_rsp_err), 256'(0));
        rsp_force_en = 1'b0;
        drain("after_timeout", 300);
`endif

        // Reset in the middle of RUN: outputs clear at once, job discarded
        core_hang = 1'b1;
        push_job(0, rand256(), rand256()[127:0], 0, 1'b1);
        for (int c = 0; c < 50 && !bus.o_busy; c++) @(negedge clk);
        check_eq("midrun_busy", 256'(bus.o_busy), 256'(1));
        repeat (3) @(negedge clk);
        check_eq("midrun_core_start", 256'(bus.o_core_start), 256'(1));
        #2 rstn = 1'b0;
        #1 check_all_zero("midrun_reset");
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (2) @(negedge clk);
        core_hang = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        push_job(1, rand256(), rand256()[127:0], 0, 1'b0);
        drain("after_reset", 300);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            push_job(0, rand256(), rand256()[127:0], $urandom_range(0, 4), 1'b0);
            push_job(1, rand256(), rand256()[127:0], $urandom_range(0, 4), 1'b0);
        end
        drain("random", 6000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
